step_shift_unit: RTL

Parametrised stepping shift register with built-in rising-edge detection and an output selector. It generalises the fixed 16-bit load/step/edge-detect/mux chain into one block: configurable width, left or right rotation, manual or timed stepping, a step counter and a four-way output select. It sits between the board switch/button inputs and the LED/seven-segment display drivers.

---
 rtl/step_shift_unit_if.sv | 26 ++
 rtl/step_shift_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/step_shift_unit_if.sv
// Bus bundle for step_shift_unit: control/data inputs and register/mux outputs.
interface step_shift_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             step;
    logic             auto_en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       out_sel;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] edge_out;
    logic [7:0]       step_cnt;
    logic [WIDTH-1:0] mux_out;

    modport master (
        output step, auto_en, dir, load, seed, d_in, out_sel,
        input  q, edge_out, step_cnt, mux_out
    );

    modport slave (
        input  step, auto_en, dir, load, seed, d_in, out_sel,
        output q, edge_out, step_cnt, mux_out
    );
endinterface

// File: rtl/step_shift_unit.sv
// Stepping rotate register with rising-edge detect, step counter and output mux.
// Define STEP_SHIFT_AUTO_EN to build the timed auto-step tick counter.
module step_shift_unit #(
    parameter int unsigned     WIDTH    = 16,
    parameter logic [WIDTH-1:0] INIT    = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned     TICK_DIV = 50_000_000
) (
    input logic             clk,
    input logic             rst,
    step_shift_unit_if.slave bus
);
    localparam int unsigned EW = (WIDTH > 8) ? WIDTH : 8;

    logic [WIDTH-1:0] q, q_next, edge_r, rot;
    logic [7:0]       cnt, cnt_next;
    logic             step_d;
    logic             auto_eff, tick_hit, step_evt;
    logic [EW-1:0]    cnt_ext;

`ifdef STEP_SHIFT_AUTO_EN
    localparam int unsigned     TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    assign auto_eff = bus.auto_en;
    assign tick_hit = bus.auto_en && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst)
            tick_cnt <= '0;
        else if (!bus.auto_en || tick_hit)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end
`else
    // TICK_DIV >= 2, so this is constant 0; auto_en stays referenced but inert.
    assign auto_eff = bus.auto_en & (TICK_DIV == 0);
    assign tick_hit = 1'b0;
`endif

    assign step_evt = (!auto_eff && bus.step && !step_d) || tick_hit;
    assign rot      = bus.dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};

    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        if (bus.load) begin
            q_next   = bus.seed;
            cnt_next = '0;
        end else if (step_evt) begin
            q_next   = rot;
            cnt_next = cnt + 8'd1;
        end
    end

    // step_d resets high so a button held through reset release is not a step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q      <= INIT;
            edge_r <= '0;
            cnt    <= '0;
            step_d <= 1'b1;
        end else begin
            q      <= q_next;
            edge_r <= q_next & ~q;
            cnt    <= cnt_next;
            step_d <= bus.step;
        end
    end

    assign cnt_ext = EW'(cnt);

    always_comb begin
        bus.mux_out = q;
        unique case (bus.out_sel)
            2'b00: bus.mux_out = q;
            2'b01: bus.mux_out = edge_r;
            2'b10: bus.mux_out = bus.d_in;
            2'b11: bus.mux_out = cnt_ext[WIDTH-1:0];
            default: bus.mux_out = q;
        endcase
    end

    assign bus.q        = q;
    assign bus.edge_out = edge_r;
    assign bus.step_cnt = cnt;
endmodule
